// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, keeps a single outstanding IMEM request and queues {pc,instr} pairs for decode.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets raise a sticky flag and halt fetching.
module fetch_queue_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     FQ_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pc_r,
   input  logic [XLEN-1:0]             pc_ex,
   input  logic [XLEN-1:0]             pc_disp,
   output logic                        imem_req,
   output logic [XLEN-1:0]             imem_addr,
   input  logic                        imem_ready,
   input  logic                        imem_rvalid,
   input  logic [XLEN-1:0]             imem_rdata,
   output logic                        dec_valid,
   input  logic                        dec_ready,
   output logic [XLEN-1:0]             dec_instr,
   output logic [XLEN-1:0]             dec_pc,
   output logic [$clog2(FQ_DEPTH):0]   fq_count,
   output logic                        fetch_misalign
);

   localparam int unsigned PW = $clog2(FQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fq_entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic [XLEN-1:0] hold_instr_q, hold_instr_d;
   logic            outstanding_q, outstanding_d;
   logic            drop_q, drop_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   fq_entry_t       mem_q [FQ_DEPTH];
   fq_entry_t       mem_d [FQ_DEPTH];

   logic [XLEN-1:0] target_c;
   fq_entry_t       head_c;
   logic            halt_c;
   logic            misalign_c;
   logic            req_c;
   logic            valid_c;
   logic            accept_c;
   logic            resp_c;
   logic            push_c;
   logic            pop_c;
   logic            nonempty_c;

   assign target_c   = pc_ex + pc_disp;
   assign head_c     = mem_q[rd_ptr_q];
   assign nonempty_c = (count_q != '0);

   // One credit per free slot; an in-flight request already owns one.
   assign req_c    = !rst && !pc_r && !halt_c && (!outstanding_q || imem_rvalid)
                     && ((count_q + CW'(outstanding_q)) < CW'(FQ_DEPTH));
   assign valid_c  = !rst && !pc_r && nonempty_c;
   assign accept_c = req_c && imem_ready;
   assign resp_c   = imem_rvalid && outstanding_q;
   assign push_c   = resp_c && !drop_q && !pc_r;
   assign pop_c    = valid_c && dec_ready;

   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      mem_d         = mem_q;
      hold_pc_d     = hold_pc_q;
      hold_instr_d  = hold_instr_q;

      // Remember the last presented head so an empty queue keeps showing it.
      if (nonempty_c) begin
         hold_pc_d    = head_c.pc;
         hold_instr_d = head_c.instr;
      end

      if (pc_r) begin
         pc_d     = target_c;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         // A request still in flight must have its response discarded later.
         if (outstanding_q && !imem_rvalid) begin
            drop_d = 1'b1;
         end else begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
         end
      end else begin
         if (resp_c) begin
            drop_d        = 1'b0;
            outstanding_d = 1'b0;
         end
         if (accept_c) begin
            pc_d          = pc_q + XLEN'(4);
            resp_pc_d     = pc_q;
            outstanding_d = 1'b1;
         end
         if (push_c) begin
            mem_d[wr_ptr_q] = '{pc: resp_pc_q, instr: imem_rdata};
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= '0;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         hold_pc_q     <= '0;
         hold_instr_q  <= '0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         hold_pc_q     <= hold_pc_d;
         hold_instr_q  <= hold_instr_d;
      end
   end

   // Queue storage is pure datapath; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef FETCH_MISALIGN_EN
   logic misalign_q, misalign_d;

   // Every redirect re-evaluates alignment, so an aligned one clears the halt.
   always_comb begin
      misalign_d = misalign_q;
      if (pc_r) begin
         misalign_d = (target_c[1:0] != 2'b00);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign halt_c     = misalign_q;
   assign misalign_c = misalign_q;
`else
   assign halt_c     = 1'b0;
   assign misalign_c = 1'b0;
`endif

   assign imem_req       = req_c;
   assign imem_addr      = pc_q;
   assign dec_valid      = valid_c;
   assign dec_pc         = rst ? '0 : (nonempty_c ? head_c.pc    : hold_pc_q);
   assign dec_instr      = rst ? '0 : (nonempty_c ? head_c.instr : hold_instr_q);
   assign fq_count       = rst ? '0 : count_q;
   assign fetch_misalign = !rst && misalign_c;

endmodule
